// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch stage: PC generation and instruction SRAM
// request.
//
// The PC sequencer leaves reset through a one-cycle BOOT slot with ce=0. It
// then fetches sequentially, takes decode redirects with one cycle of
// latency, and holds while the pipeline stalls. A redirect that arrives
// during a stall is parked in a pending slot. If several arrive, the last
// one wins. The parked redirect is consumed on the first unstalled cycle.
//
// Parameters
//   RESET_PC        first fetch address after reset
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous, active-high reset
//   stall[5:0]      pipeline stall vector; only bit0 (PC stop) is used here
//   br_bus[32:0]    {br_e, br_addr[31:0]} redirect from decode
//   if_to_id_bus    {ce, pc[31:0]} fetch slot handed to decode
//   inst_sram_en    SRAM read enable (data returns one cycle later)
//   inst_sram_wen   constant 0
//   inst_sram_addr  equals pc
//   inst_sram_wdata constant 0
//   if_adel         fetch address misaligned while ce=1
//   if_badvaddr     equals pc
//   perf_fetch_cnt  fetch counter (0 unless IF_FETCH_PERF_EN)
//   perf_stall_cnt  stall counter (0 unless IF_FETCH_PERF_EN)
//
// Build option: define IF_FETCH_PERF_EN to build the performance counters.
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  output logic [32:0] if_to_id_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  output logic        if_adel,
  output logic [31:0] if_badvaddr,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        ce_reg, ce_next;
  logic        pend_reg, pend_next;
  logic [31:0] pend_addr_reg, pend_addr_next;

  logic        br_e;
  logic [31:0] br_addr;
  logic        pc_stop;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];
  assign pc_stop = stall[0];

  // The IF/ID stop and higher stall bits belong to later stages.
  logic unused_stall_bits;
  assign unused_stall_bits = ^stall[5:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= BOOT;
      pc_reg        <= RESET_PC - 32'd4;
      ce_reg        <= 1'b0;
      pend_reg      <= 1'b0;
      pend_addr_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      ce_reg        <= ce_next;
      pend_reg      <= pend_next;
      pend_addr_reg <= pend_addr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    ce_next        = ce_reg;
    pend_next      = pend_reg;
    pend_addr_next = pend_addr_reg;
    case (state_reg)
      BOOT: begin
        state_next = RUN;
        pc_next    = RESET_PC;
        ce_next    = 1'b1;
      end
      RUN, HOLD: begin
        if (!pc_stop) begin
          // HOLD and RUN advance identically once the stall drops, so a
          // parked redirect costs no extra bubble.
          state_next = RUN;
          if (br_e)
            pc_next = br_addr;
          else if (pend_reg)
            pc_next = pend_addr_reg;
          else
            pc_next = pc_reg + 32'd4;  // wraps modulo 2^32
          pend_next = 1'b0;
        end else begin
          state_next = HOLD;
          if (br_e) begin
            pend_next      = 1'b1;
            pend_addr_next = br_addr;
          end
        end
      end
      default: begin
        state_next = BOOT;
        ce_next    = 1'b0;
      end
    endcase
  end

  assign if_adel         = ce_reg & (pc_reg[1:0] != 2'b00);
  assign if_badvaddr     = pc_reg;
  assign if_to_id_bus    = {ce_reg, pc_reg};
  assign inst_sram_en    = ce_reg & ~if_adel;
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_wen   = 4'd0;
  assign inst_sram_wdata = 32'd0;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt_reg;
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_reg <= 32'd0;
      stall_cnt_reg <= 32'd0;
    end else begin
      if (inst_sram_en && !pc_stop)
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      if (ce_reg && pc_stop)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_reg;
  assign perf_stall_cnt = stall_cnt_reg;
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- self-checking bench for if_fetch.
//
// The bench runs directed scenarios and then randomized cycles. A cycle-level
// reference model, written from the fetch rules, follows the DUT, and every
// output is compared after each clock edge.
// ---------------------------------------------------------------------------
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
`ifdef IF_FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = 6'd0;
  logic [32:0] br_bus = 33'd0;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        if_adel;
  logic [31:0] if_badvaddr;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          m_booting;
  logic [31:0] m_pc;
  bit          m_ce;
  bit          m_pend;
  logic [31:0] m_tgt;
  logic [31:0] m_fetch;
  logic [31:0] m_stalls;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .br_bus         (br_bus),
    .if_to_id_bus   (if_to_id_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .if_adel        (if_adel),
    .if_badvaddr    (if_badvaddr),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs just sampled.
  task automatic model_tick(input bit r, input bit st0, input bit be, input logic [31:0] ba);
    bit misaligned;
    if (r) begin
      m_booting = 1; m_pc = RESET_PC - 32'd4; m_ce = 0;
      m_pend = 0; m_tgt = 0; m_fetch = 0; m_stalls = 0;
      return;
    end
    misaligned = (m_pc % 4) != 0;
    if (PERF) begin
      if (m_ce && !misaligned && !st0) m_fetch = m_fetch + 32'd1;
      if (m_ce && st0) m_stalls = m_stalls + 32'd1;
    end
    if (m_booting) begin
      m_booting = 0; m_pc = RESET_PC; m_ce = 1;
    end else if (!st0) begin
      if (be)          m_pc = ba;
      else if (m_pend) m_pc = m_tgt;
      else             m_pc = m_pc + 32'd4;
      m_pend = 0;
    end else if (be) begin
      m_pend = 1; m_tgt = ba;
    end
  endtask

  task automatic compare_all();
    bit adel;
    adel = m_ce && ((m_pc % 4) != 0);
    check("ce", {31'd0, if_to_id_bus[32]}, {31'd0, m_ce});
    check("pc", if_to_id_bus[31:0], m_pc);
    check("sram_addr", inst_sram_addr, m_pc);
    check("sram_en", {31'd0, inst_sram_en}, {31'd0, m_ce && !adel});
    check("adel", {31'd0, if_adel}, {31'd0, adel});
    check("badvaddr", if_badvaddr, m_pc);
    check("sram_wen_wdata", {28'd0, inst_sram_wen} | inst_sram_wdata, 32'd0);
    check("perf_fetch", perf_fetch_cnt, m_fetch);
    check("perf_stall", perf_stall_cnt, m_stalls);
  endtask

  task automatic step(input bit r, input logic [5:0] st, input bit be, input logic [31:0] ba);
    @(negedge clk);
    rst    = r;
    stall  = st;
    br_bus = {be, ba};
    @(posedge clk);
    model_tick(r, st[0], be, ba);
    #1;
    compare_all();
    $display("cyc rst=%0b stall=%02h br=%0b:%h -> ce=%0b pc=%h en=%0b adel=%0b",
             r, st, be, ba, if_to_id_bus[32], if_to_id_bus[31:0], inst_sram_en, if_adel);
  endtask

  initial begin
    logic [31:0] ba;
    int run_n;
    // Reset state.
    step(1, 6'd0, 0, 32'd0);
    step(1, 6'h01, 1, 32'h1234_0000);
    check("rst_pc", if_to_id_bus[31:0], 32'hBFBF_FFFC);
    check("rst_ce", {31'd0, if_to_id_bus[32]}, 32'd0);
    check("rst_en", {31'd0, inst_sram_en}, 32'd0);

    // Boot sequence.
    step(0, 6'd0, 0, 32'd0);
    check("boot_pc0", if_to_id_bus[31:0], 32'hBFC0_0000);
    check("boot_ce", {31'd0, if_to_id_bus[32]}, 32'd1);
    step(0, 6'd0, 0, 32'd0);
    check("boot_pc1", if_to_id_bus[31:0], 32'hBFC0_0004);
    step(0, 6'd0, 0, 32'd0);
    check("boot_pc2", if_to_id_bus[31:0], 32'hBFC0_0008);
    step(0, 6'd0, 0, 32'd0);
    step(0, 6'd0, 0, 32'd0);

    // Redirect at pc=BFC0_0010, one cycle of latency.
    check("pre_br_pc", if_to_id_bus[31:0], 32'hBFC0_0010);
    step(0, 6'd0, 1, 32'hBFC0_0100);
    check("br_pc", if_to_id_bus[31:0], 32'hBFC0_0100);
    step(0, 6'd0, 0, 32'd0);
    check("br_pc_next", if_to_id_bus[31:0], 32'hBFC0_0104);

    // Two redirects during a stall: the last one wins.
    step(0, 6'h01, 1, 32'h0000_2000);
    check("stall_hold1", if_to_id_bus[31:0], 32'hBFC0_0104);
    step(0, 6'h03, 1, 32'h0000_3000);
    check("stall_hold2", if_to_id_bus[31:0], 32'hBFC0_0104);
    step(0, 6'h01, 0, 32'd0);
    check("stall_hold3", if_to_id_bus[31:0], 32'hBFC0_0104);
    step(0, 6'd0, 0, 32'd0);
    check("pend_taken", if_to_id_bus[31:0], 32'h0000_3000);
    step(0, 6'd0, 0, 32'd0);
    check("pend_cleared", if_to_id_bus[31:0], 32'h0000_3004);

    // Misaligned target.
    step(0, 6'd0, 1, 32'h0000_2002);
    check("mis_adel", {31'd0, if_adel}, 32'd1);
    check("mis_bad", if_badvaddr, 32'h0000_2002);
    check("mis_en", {31'd0, inst_sram_en}, 32'd0);
    step(0, 6'd0, 0, 32'd0);
    check("mis_next", if_to_id_bus[31:0], 32'h0000_2006);
    check("mis_adel2", {31'd0, if_adel}, 32'd1);

    // Wrap from FFFF_FFFC to 0.
    step(0, 6'd0, 1, 32'hFFFF_FFFC);
    step(0, 6'd0, 0, 32'd0);
    check("wrap_pc", if_to_id_bus[31:0], 32'h0000_0000);

    // Reset during a stall discards the pending redirect.
    step(0, 6'h01, 1, 32'h0000_5000);
    step(1, 6'h01, 0, 32'd0);
    step(0, 6'd0, 0, 32'd0);
    check("rst_pend_pc0", if_to_id_bus[31:0], 32'hBFC0_0000);
    step(0, 6'd0, 0, 32'd0);
    check("rst_pend_pc1", if_to_id_bus[31:0], 32'hBFC0_0004);

    // Performance counters: 10 run cycles and 4 stall cycles.
    step(1, 6'd0, 0, 32'd0);
    step(0, 6'd0, 0, 32'd0);
    for (int i = 0; i < 10; i++) step(0, 6'd0, 0, 32'd0);
    for (int i = 0; i < 4; i++) step(0, 6'h01, 0, 32'd0);
    check("perf_fetch_10", perf_fetch_cnt, PERF ? 32'd10 : 32'd0);
    check("perf_stall_4", perf_stall_cnt, PERF ? 32'd4 : 32'd0);

    // Randomized traffic.
    run_n = 1500;
    for (int i = 0; i < run_n; i++) begin
      ba = $urandom;
      if ($urandom_range(7) != 0) ba[1:0] = 2'b00;
      step($urandom_range(99) == 0,
           6'($urandom_range(63)) & (($urandom_range(9) < 3) ? 6'h3F : 6'h3E),
           $urandom_range(4) == 0, ba);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
